// File: rtl/panel_scan.sv
// HUB75-style panel scanner: per scan line and bit plane it shifts 64 columns, blanks, latches, then shows for BASE_TICKS<<plane cycles.
// All outputs are registered and change one clock after the state decision; there is no backpressure, and rd_data must return one cycle after rd_addr.
module panel_scan #(
    parameter int PWM_WIDTH  = 4,
    parameter int BASE_TICKS = 8
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    output logic [8:0] rd_addr,
    output logic [2:0] rd_plane,
    input  logic [5:0] rd_data,
    output logic       sclk,
    output logic [5:0] rgb,
    output logic       lat,
    output logic       oe_n,
    output logic [2:0] line,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;

    localparam logic [2:0]  LAST_PLANE = 3'(PWM_WIDTH - 1);
    localparam logic [15:0] BASE       = 16'(BASE_TICKS);
    localparam logic [7:0]  SHIFT_LAST = 8'd128;

    state_t      state, state_nx;
    logic [7:0]  sh_cnt, sh_nx;
    logic [15:0] show_cnt, show_nx;
    logic [2:0]  plane, plane_nx;
    logic [2:0]  scan, scan_nx;
    logic        frame_done_nx;
    logic        sclk_nx;
    logic        fetch_nx;
    logic [5:0]  col_nx;

    always_comb begin
        state_nx      = state;
        sh_nx         = sh_cnt;
        show_nx       = show_cnt;
        plane_nx      = plane;
        scan_nx       = scan;
        frame_done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = SHIFT;
                    sh_nx    = 8'd0;
                    plane_nx = 3'd0;
                    scan_nx  = 3'd0;
                end
            end
            SHIFT: begin
                if (sh_cnt == SHIFT_LAST) begin
                    state_nx = BLANK;
                    sh_nx    = 8'd0;
                end else begin
                    sh_nx = sh_cnt + 8'd1;
                end
            end
            BLANK: state_nx = LATCH;
            LATCH: begin
                state_nx = SHOW;
                show_nx  = (BASE << plane) - 16'd1;
            end
            SHOW: begin
                if (show_cnt == 16'd0) begin
                    state_nx = SHIFT;
                    sh_nx    = 8'd0;
                    if (plane != LAST_PLANE) begin
                        plane_nx = plane + 3'd1;
                    end else begin
                        plane_nx = 3'd0;
                        scan_nx  = scan + 3'd1;
                        if (scan == 3'd7) begin
                            // Enable is only re-examined here, so a frame is never cut short.
                            frame_done_nx = 1'b1;
                            state_nx      = enable ? SHIFT : IDLE;
                        end
                    end
                end else begin
                    show_nx = show_cnt - 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Even SHIFT steps fetch a column (descending); every even step after the first raises sclk.
    always_comb begin
        col_nx   = 6'd63 - sh_nx[6:1];
        sclk_nx  = (state_nx == SHIFT) && !sh_nx[0] && (sh_nx != 8'd0);
        fetch_nx = (state_nx == SHIFT) && !sh_nx[0] && (sh_nx != SHIFT_LAST);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            sh_cnt     <= 8'd0;
            show_cnt   <= 16'd0;
            plane      <= 3'd0;
            scan       <= 3'd0;
            rd_addr    <= 9'd0;
            rd_plane   <= 3'd0;
            sclk       <= 1'b0;
            rgb        <= 6'd0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            line       <= 3'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            sh_cnt     <= sh_nx;
            show_cnt   <= show_nx;
            plane      <= plane_nx;
            scan       <= scan_nx;
            sclk       <= sclk_nx;
            lat        <= (state_nx == LATCH);
            oe_n       <= (state_nx != SHOW);
            busy       <= (state_nx != IDLE);
            frame_done <= frame_done_nx;
            if (state_nx == BLANK) begin
                line <= scan_nx;
            end
            if (fetch_nx) begin
                rd_addr  <= {scan_nx, col_nx};
                rd_plane <= plane_nx;
            end
            // rd_data answering the previous address arrives during the odd step.
            if ((state == SHIFT) && sh_cnt[0]) begin
                rgb <= rd_data;
            end
        end
    end

endmodule
